// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_wb_pkg;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_entry_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // One-hot register mask with x0 always cleared, so hazard logic never sees x0 busy.
  function automatic logic [31:0] addr_bit(input logic [4:0] addr);
    logic [31:0] mask;
    mask = 32'd0;
    if (addr != REG_ZERO) mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Requester handshakes, register-file write port and status for the writeback arbiter.
interface regfile_wb_arbiter_if;
  logic        iValidA;
  logic [4:0]  iAddrA;
  logic [31:0] iDataA;
  logic        oReadyA;
  logic        iValidB;
  logic [4:0]  iAddrB;
  logic [31:0] iDataB;
  logic        oReadyB;
  logic        oWe;
  logic [4:0]  oWaddr;
  logic [31:0] oWdata;
  logic [31:0] oPending;
  logic        oIdle;

  modport slave (
    input  iValidA, iAddrA, iDataA, iValidB, iAddrB, iDataB,
    output oReadyA, oReadyB, oWe, oWaddr, oWdata, oPending, oIdle
  );

  modport master (
    output iValidA, iAddrA, iDataA, iValidB, iAddrB, iDataB,
    input  oReadyA, oReadyB, oWe, oWaddr, oWdata, oPending, oIdle
  );
endinterface

// File: rtl/wb_fifo.sv
// Small writeback FIFO with a combinational head and a per-slot valid/addr view for hazard tracking.
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  push,
  input  logic                  pop,
  input  wb_entry_t             din,
  output wb_entry_t             dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH-1:0]      entry_valid,
  output logic [DEPTH-1:0][4:0] entry_addr
);
  localparam int PW = $clog2(DEPTH);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (PW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; slot validity comes purely from the pointers and count.
  always_ff @(posedge iClk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_view
    logic [PW-1:0] offset;
    assign offset          = PW'(gi) - rd_ptr_reg;
    assign entry_valid[gi] = ({1'b0, offset} < count_reg);
    assign entry_addr[gi]  = mem[gi].addr;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two buffered writeback requesters.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 iClk,
  input  logic                 iReset,
  regfile_wb_arbiter_if.slave  bus
);
  wb_entry_t              head_a, head_b, head, in_a, in_b;
  logic                   empty_a, empty_b, full_a, full_b;
  logic                   pop_a, pop_b;
  logic [DEPTH-1:0]       valid_a, valid_b;
  logic [DEPTH-1:0][4:0]  addr_a, addr_b;
  logic                   grant_valid;
  req_e                   grant_sel;
  req_e                   last_reg;
  logic                   we;

  assign in_a = '{addr: bus.iAddrA, data: bus.iDataA};
  assign in_b = '{addr: bus.iAddrB, data: bus.iDataB};

  assign bus.oReadyA = !iReset && !full_a;
  assign bus.oReadyB = !iReset && !full_b;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .iClk(iClk), .iReset(iReset),
    .push(bus.iValidA && bus.oReadyA), .pop(pop_a),
    .din(in_a), .dout(head_a), .empty(empty_a), .full(full_a),
    .entry_valid(valid_a), .entry_addr(addr_a)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .iClk(iClk), .iReset(iReset),
    .push(bus.iValidB && bus.oReadyB), .pop(pop_b),
    .din(in_b), .dout(head_b), .empty(empty_b), .full(full_b),
    .entry_valid(valid_b), .entry_addr(addr_b)
  );

  always_comb begin
    grant_valid = !empty_a || !empty_b;
    grant_sel   = REQ_A;
    if (!empty_a && !empty_b) grant_sel = (last_reg == REQ_A) ? REQ_B : REQ_A;
    else if (empty_a)         grant_sel = REQ_B;
  end

  assign pop_a = grant_valid && (grant_sel == REQ_A);
  assign pop_b = grant_valid && (grant_sel == REQ_B);
  assign head  = (grant_sel == REQ_A) ? head_a : head_b;

  // An x0 head still consumes its grant slot; it just never reaches the write port.
  assign we         = grant_valid && (head.addr != REG_ZERO);
  assign bus.oWe    = we;
  assign bus.oWaddr = we ? head.addr : 5'd0;
  assign bus.oWdata = we ? head.data : 32'd0;
  assign bus.oIdle  = empty_a && empty_b;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset)           last_reg <= REQ_B;
    else if (grant_valid) last_reg <= grant_sel;
  end

  always_comb begin
    bus.oPending = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_a[i]) bus.oPending = bus.oPending | addr_bit(addr_a[i]);
      if (valid_b[i]) bus.oPending = bus.oPending | addr_bit(addr_b[i]);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed vectors plus a constrained random phase.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
  import regfile_wb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter #(.DEPTH(2)) dut (
    .iClk(clk),
    .iReset(rst),
    .bus(bus.slave)
  );

  int errors = 0;
  int checks = 0;

  wb_entry_t exp_q[$];
  wb_entry_t qa[$];
  wb_entry_t qb[$];
  bit        rand_mode = 1'b0;
  logic [31:0] pend_exp;

  logic [4:0]  sa_addr [8];
  logic [4:0]  sb_addr [8];
  logic [31:0] sa_data [8];
  logic [31:0] sb_data [8];
  bit          rdy_a_h [16];
  bit          rdy_b_h [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got write to %h but none expected", name, act);
  endtask

  // Monitor: every presented write is popped against the scoreboard.
  always @(negedge clk) begin
    wb_entry_t e;
    if (!rst) begin
      if (rand_mode) begin
        pend_exp = 32'd0;
        foreach (qa[i]) pend_exp = pend_exp | addr_bit(qa[i].addr);
        foreach (qb[i]) pend_exp = pend_exp | addr_bit(qb[i].addr);
        chk("rand_pending", bus.oPending, pend_exp);
        if (bus.oWe) begin
          if (bus.oWaddr < 5'd16) begin
            if (qa.size() == 0) fail_now("rand_unexpected_a", 32'(bus.oWaddr));
            else begin
              e = qa.pop_front();
              chk("rand_a_addr", 32'(bus.oWaddr), 32'(e.addr));
              chk("rand_a_data", bus.oWdata, e.data);
            end
          end else begin
            if (qb.size() == 0) fail_now("rand_unexpected_b", 32'(bus.oWaddr));
            else begin
              e = qb.pop_front();
              chk("rand_b_addr", 32'(bus.oWaddr), 32'(e.addr));
              chk("rand_b_data", bus.oWdata, e.data);
            end
          end
        end
      end else if (bus.oWe) begin
        if (exp_q.size() == 0) fail_now("unexpected_write", 32'(bus.oWaddr));
        else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(bus.oWaddr), 32'(e.addr));
          chk("wr_data", bus.oWdata, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iValidA = 1'b0; bus.iAddrA = 5'd0; bus.iDataA = 32'd0;
    bus.iValidB = 1'b0; bus.iAddrB = 5'd0; bus.iDataB = 32'd0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (!bus.oIdle && n < 50) begin
      tick();
      n++;
    end
    tick();
    chk({name, "_idle"}, 32'(bus.oIdle), 32'd1);
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_ready_a", 32'(bus.oReadyA), 32'd0);
    chk("rst_ready_b", 32'(bus.oReadyB), 32'd0);
    chk("rst_we", 32'(bus.oWe), 32'd0);
    chk("rst_waddr", 32'(bus.oWaddr), 32'd0);
    chk("rst_wdata", bus.oWdata, 32'd0);
    chk("rst_pending", bus.oPending, 32'd0);
    chk("rst_idle", 32'(bus.oIdle), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_ready_a", 32'(bus.oReadyA), 32'd1);
    chk("rel_ready_b", 32'(bus.oReadyB), 32'd1);
    tick();
  endtask

  // Offer the sa_/sb_ streams back-to-back, holding each entry until accepted.
  task automatic stream(input int na, input int nb, input int ncyc);
    int ia = 0;
    int ib = 0;
    bit acc_a, acc_b;
    for (int c = 0; c < ncyc; c++) begin
      rdy_a_h[c]  = bus.oReadyA;
      rdy_b_h[c]  = bus.oReadyB;
      bus.iValidA = (ia < na);
      bus.iAddrA  = (ia < na) ? sa_addr[ia] : 5'd0;
      bus.iDataA  = (ia < na) ? sa_data[ia] : 32'd0;
      bus.iValidB = (ib < nb);
      bus.iAddrB  = (ib < nb) ? sb_addr[ib] : 5'd0;
      bus.iDataB  = (ib < nb) ? sb_data[ib] : 32'd0;
      acc_a = bus.iValidA && bus.oReadyA;
      acc_b = bus.iValidB && bus.oReadyB;
      tick();
      if (acc_a) ia++;
      if (acc_b) ib++;
    end
    idle_inputs();
    chk("stream_all_a_accepted", 32'(ia), 32'(na));
    chk("stream_all_b_accepted", 32'(ib), 32'(nb));
  endtask

  function automatic wb_entry_t mk(input logic [4:0] a, input logic [31:0] d);
    wb_entry_t e;
    e.addr = a;
    e.data = d;
    return e;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hold_a, hold_b, acc_a, acc_b;
    idle_inputs();
    do_reset();

    // Single write: visible one cycle after acceptance.
    bus.iValidA = 1'b1; bus.iAddrA = 5'd5; bus.iDataA = 32'hDEADBEEF;
    exp_q.push_back(mk(5'd5, 32'hDEADBEEF));
    tick();
    idle_inputs();
    chk("single_we", 32'(bus.oWe), 32'd1);
    chk("single_pending", bus.oPending, 32'h0000_0020);
    tick();
    chk("single_pending_clr", bus.oPending, 32'd0);
    chk("single_we_clr", 32'(bus.oWe), 32'd0);
    drain("single");

    // Contention from reset: A wins first, then strict alternation.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      sa_addr[i] = 5'(1 + i);  sa_data[i] = 32'hA000_0000 + 32'(i);
      sb_addr[i] = 5'(11 + i); sb_data[i] = 32'hB000_0000 + 32'(i);
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(sa_addr[i], sa_data[i]));
      exp_q.push_back(mk(sb_addr[i], sb_data[i]));
    end
    stream(3, 3, 6);
    chk("cont_rdy_a_c2", 32'(rdy_a_h[2]), 32'd1);
    chk("cont_rdy_b_c2", 32'(rdy_b_h[2]), 32'd0);
    chk("cont_rdy_a_c3", 32'(rdy_a_h[3]), 32'd0);
    chk("cont_rdy_b_c3", 32'(rdy_b_h[3]), 32'd1);
    drain("cont");

    // x0 write is swallowed but still hands the next grant to A.
    bus.iValidA = 1'b1; bus.iAddrA = 5'd4; bus.iDataA = 32'h0000_0044;
    exp_q.push_back(mk(5'd4, 32'h0000_0044));
    tick();
    idle_inputs();
    bus.iValidB = 1'b1; bus.iAddrB = 5'd0; bus.iDataB = 32'h0000_1234;
    tick();
    idle_inputs();
    chk("x0_we", 32'(bus.oWe), 32'd0);
    chk("x0_waddr", 32'(bus.oWaddr), 32'd0);
    chk("x0_pending", bus.oPending, 32'd0);
    chk("x0_not_idle", 32'(bus.oIdle), 32'd0);
    bus.iValidA = 1'b1; bus.iAddrA = 5'd9;  bus.iDataA = 32'h0000_0999;
    bus.iValidB = 1'b1; bus.iAddrB = 5'd20; bus.iDataB = 32'h0000_2020;
    exp_q.push_back(mk(5'd9, 32'h0000_0999));
    exp_q.push_back(mk(5'd20, 32'h0000_2020));
    tick();
    idle_inputs();
    drain("x0");

    // Full FIFO: A held valid while B keeps the arbiter busy.
    for (int i = 0; i < 4; i++) begin
      sa_addr[i] = 5'(21 + i); sa_data[i] = 32'hCA00_0000 + 32'(i);
      sb_addr[i] = 5'(25 + i); sb_data[i] = 32'hCB00_0000 + 32'(i);
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(sa_addr[i], sa_data[i]));
      exp_q.push_back(mk(sb_addr[i], sb_data[i]));
    end
    stream(4, 4, 7);
    chk("full_rdy_a_c3", 32'(rdy_a_h[3]), 32'd0);
    chk("full_rdy_a_c4", 32'(rdy_a_h[4]), 32'd1);
    chk("full_rdy_a_c5", 32'(rdy_a_h[5]), 32'd0);
    chk("full_rdy_b_c4", 32'(rdy_b_h[4]), 32'd0);
    chk("full_rdy_b_c5", 32'(rdy_b_h[5]), 32'd1);
    drain("full");

    // Reset mid-operation: only the two writes before reset may appear.
    exp_q.push_back(mk(5'd1, 32'h0000_0001));
    exp_q.push_back(mk(5'd17, 32'h0000_0017));
    bus.iValidA = 1'b1; bus.iAddrA = 5'd1; bus.iDataA = 32'h0000_0001;
    bus.iValidB = 1'b1; bus.iAddrB = 5'd17; bus.iDataB = 32'h0000_0017;
    tick();
    bus.iAddrA = 5'd2;  bus.iDataA = 32'h0000_0002;
    bus.iAddrB = 5'd18; bus.iDataB = 32'h0000_0018;
    tick();
    bus.iAddrA = 5'd3;  bus.iDataA = 32'h0000_0003;
    bus.iAddrB = 5'd19; bus.iDataB = 32'h0000_0019;
    tick();
    idle_inputs();
    chk("mid_pending_before", bus.oPending, 32'h0004_000C);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_we", 32'(bus.oWe), 32'd0);
    chk("mid_pending", bus.oPending, 32'd0);
    chk("mid_idle", 32'(bus.oIdle), 32'd1);
    chk("mid_ready_a", 32'(bus.oReadyA), 32'd0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_idle", 32'(bus.oIdle), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    chk("post_no_stale", 32'(exp_q.size()), 32'd0);
    chk("post_we", 32'(bus.oWe), 32'd0);

    // Random phase: A uses x1..x15, B uses x16..x31 so the monitor can route writes.
    rand_mode = 1'b1;
    hold_a = 1'b0;
    hold_b = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!hold_a) begin
        bus.iValidA = 1'($urandom_range(0, 1));
        bus.iAddrA  = 5'($urandom_range(1, 15));
        bus.iDataA  = $urandom;
      end
      if (!hold_b) begin
        bus.iValidB = 1'($urandom_range(0, 1));
        bus.iAddrB  = 5'($urandom_range(16, 31));
        bus.iDataB  = $urandom;
      end
      acc_a = bus.iValidA && bus.oReadyA;
      acc_b = bus.iValidB && bus.oReadyB;
      tick();
      if (acc_a) qa.push_back(mk(bus.iAddrA, bus.iDataA));
      if (acc_b) qb.push_back(mk(bus.iAddrB, bus.iDataB));
      hold_a = bus.iValidA && !acc_a;
      hold_b = bus.iValidB && !acc_b;
    end
    idle_inputs();
    drain("rand");
    chk("rand_queues_empty", 32'(qa.size() + qb.size()), 32'd0);
    rand_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
